// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit for a classic 5-stage pipeline.
// Computes the EX operand-mux selects one cycle early in ID, detects
// load-use hazards and holds PC and IF/ID while injecting ID/EX bubbles
// for LOAD_LAT cycles. It also keeps a saturating count of stall cycles.
module hazard_forward_unit #(
   parameter int NB_ADDR  = 5,
   parameter int N_SRC    = 2,
   parameter int LOAD_LAT = 1,
   parameter int NB_CNT   = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_flush,
   input  logic                     i_valid_id,
   input  logic [N_SRC*NB_ADDR-1:0] i_src_addr_id,
   input  logic [N_SRC-1:0]         i_src_used_id,
   input  logic [NB_ADDR-1:0]       i_wr_addr_ex,
   input  logic [NB_ADDR-1:0]       i_wr_addr_mem,
   input  logic [NB_ADDR-1:0]       i_wr_addr_wb,
   input  logic                     i_wr_en_ex,
   input  logic                     i_wr_en_mem,
   input  logic                     i_wr_en_wb,
   input  logic                     i_mem_read_ex,
   output logic [2*N_SRC-1:0]       o_fwd_sel_ex,
   output logic                     o_valid_ex,
   output logic                     o_stall_pc,
   output logic                     o_stall_ifid,
   output logic                     o_bubble_idex,
   output logic [NB_CNT-1:0]        o_stall_count
);

   localparam int NB_LAT = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT + 1);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EX  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [NB_LAT-1:0]   r_cnt;
   logic [NB_LAT-1:0]   w_nextCnt;
   logic                w_stall;
   logic                w_loadUse;

   logic [N_SRC-1:0]    w_live;
   logic [N_SRC-1:0]    w_exHit;
   logic [N_SRC-1:0]    w_memHit;
   logic [N_SRC-1:0]    w_wbHit;
   logic [2*N_SRC-1:0]  w_fwdSel;

   logic [2*N_SRC-1:0]  r_fwdSelEx;
   logic                r_validEx;
   logic [NB_CNT-1:0]   r_stallCount;

   // Per-source match against each producer stage; register 0 never matches.
   // The youngest producer (EX) wins over MEM. A WB match reads the register
   // file because it writes through in the same cycle.
   genvar g;
   generate
      for (g = 0; g < N_SRC; g++) begin : g_src
         logic [NB_ADDR-1:0] w_srcAddr;
         assign w_srcAddr   = i_src_addr_id[g*NB_ADDR +: NB_ADDR];
         assign w_live[g]   = i_src_used_id[g] && (w_srcAddr != '0);
         assign w_exHit[g]  = w_live[g] && i_wr_en_ex  && (w_srcAddr == i_wr_addr_ex);
         assign w_memHit[g] = w_live[g] && i_wr_en_mem && (w_srcAddr == i_wr_addr_mem);
         assign w_wbHit[g]  = w_live[g] && i_wr_en_wb  && (w_srcAddr == i_wr_addr_wb);
         assign w_fwdSel[2*g +: 2] = (w_exHit[g] && !i_mem_read_ex) ? SEL_EX  :
                                     w_memHit[g]                   ? SEL_MEM :
                                     w_wbHit[g]                    ? SEL_RF  :
                                                                     SEL_RF;
      end
   endgenerate

   // A load in EX feeding a live source can only be caught while IDLE.
   assign w_loadUse = (r_state == ST_IDLE) && i_valid_id && i_mem_read_ex && (|w_exHit);

   // Next-state and stall outputs. r_cnt holds the number of STALL cycles
   // still to come, so the detect cycle plus LOAD_LAT-1 STALL cycles give
   // exactly LOAD_LAT stall cycles. Flush overrides everything.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_stall     = 1'b0;
      if (i_flush) begin
         w_nextState = ST_IDLE;
         w_nextCnt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_loadUse) begin
                  w_stall = 1'b1;
                  if (LOAD_LAT > 1) begin
                     w_nextState = ST_STALL;
                     w_nextCnt   = NB_LAT'(LOAD_LAT - 1);
                  end
               end
            end
            ST_STALL: begin
               w_stall   = 1'b1;
               w_nextCnt = r_cnt - NB_LAT'(1);
               if (r_cnt <= NB_LAT'(1)) begin
                  w_nextState = ST_IDLE;
                  w_nextCnt   = '0;
               end
            end
            default: begin
               w_nextState = ST_IDLE;
               w_nextCnt   = '0;
            end
         endcase
      end
   end

   // FSM state and remaining-stall counter.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   // ID/EX register for the operand selects; a bubble clears valid and selects.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_fwdSelEx <= '0;
         r_validEx  <= 1'b0;
      end else if (i_flush || w_stall || !i_valid_id) begin
         r_fwdSelEx <= '0;
         r_validEx  <= 1'b0;
      end else begin
         r_fwdSelEx <= w_fwdSel;
         r_validEx  <= 1'b1;
      end
   end

   // Saturating stall-cycle counter; flush suppresses the stall so it never counts.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_stallCount <= '0;
      end else if (w_stall && (r_stallCount != '1)) begin
         r_stallCount <= r_stallCount + NB_CNT'(1);
      end
   end

   assign o_fwd_sel_ex  = r_fwdSelEx;
   assign o_valid_ex    = r_validEx;
   assign o_stall_pc    = w_stall;
   assign o_stall_ifid  = w_stall;
   assign o_bubble_idex = w_stall;
   assign o_stall_count = r_stallCount;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit. Two instances share the inputs:
// dutA with LOAD_LAT=1 and a 16-bit counter, and dutB with LOAD_LAT=3 and a
// 4-bit counter, so counter saturation is quick to reach.
module tb_hazard_forward_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        validId;
   logic [9:0]  srcAddr;
   logic [1:0]  srcUsed;
   logic [4:0]  wrAddrEx, wrAddrMem, wrAddrWb;
   logic        wrEnEx, wrEnMem, wrEnWb, memReadEx;

   logic [3:0]  selA, selB;
   logic        validA, validB;
   logic        stallPcA, stallIfidA, bubbleA;
   logic        stallPcB, stallIfidB, bubbleB;
   logic [15:0] cntA;
   logic [3:0]  cntB;

   int testCount = 0;
   int failCount = 0;

   typedef struct {
      int          inst;
      string       tag;
      logic [3:0]  sel;
      logic        valid;
      logic [15:0] cnt;
   } sb_t;

   sb_t sbQ[$];

   hazard_forward_unit #(.NB_ADDR(5), .N_SRC(2), .LOAD_LAT(1), .NB_CNT(16)) dutA (
      .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_valid_id(validId),
      .i_src_addr_id(srcAddr), .i_src_used_id(srcUsed),
      .i_wr_addr_ex(wrAddrEx), .i_wr_addr_mem(wrAddrMem), .i_wr_addr_wb(wrAddrWb),
      .i_wr_en_ex(wrEnEx), .i_wr_en_mem(wrEnMem), .i_wr_en_wb(wrEnWb),
      .i_mem_read_ex(memReadEx),
      .o_fwd_sel_ex(selA), .o_valid_ex(validA),
      .o_stall_pc(stallPcA), .o_stall_ifid(stallIfidA), .o_bubble_idex(bubbleA),
      .o_stall_count(cntA)
   );

   hazard_forward_unit #(.NB_ADDR(5), .N_SRC(2), .LOAD_LAT(3), .NB_CNT(4)) dutB (
      .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_valid_id(validId),
      .i_src_addr_id(srcAddr), .i_src_used_id(srcUsed),
      .i_wr_addr_ex(wrAddrEx), .i_wr_addr_mem(wrAddrMem), .i_wr_addr_wb(wrAddrWb),
      .i_wr_en_ex(wrEnEx), .i_wr_en_mem(wrEnMem), .i_wr_en_wb(wrEnWb),
      .i_mem_read_ex(memReadEx),
      .o_fwd_sel_ex(selB), .o_valid_ex(validB),
      .o_stall_pc(stallPcB), .o_stall_ifid(stallIfidB), .o_bubble_idex(bubbleB),
      .o_stall_count(cntB)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive all ID/pipeline inputs in one go.
   task automatic setIn(input logic v, input logic fl, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] wEx, input logic enEx, input logic ld,
                        input logic [4:0] wMem, input logic enMem, input logic [4:0] wWb, input logic enWb);
      validId   = v;
      flush     = fl;
      srcAddr   = {s1, s0};
      srcUsed   = used;
      wrAddrEx  = wEx;
      wrEnEx    = enEx;
      memReadEx = ld;
      wrAddrMem = wMem;
      wrEnMem   = enMem;
      wrAddrWb  = wWb;
      wrEnWb    = enWb;
   endtask

   task automatic setIdle();
      setIn(1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   // Called at a falling edge with inputs already driven: checks the
   // combinational stall outputs now and queues the registered results
   // expected after the next rising edge.
   task automatic applyStimulus(input int inst, input string tag, input logic expStall,
                                input logic [3:0] expSel, input logic expValid, input logic [15:0] expCnt);
      sb_t e;
      #1;
      checkOutput({tag, "_stallPc"},   (inst == 0) ? 32'(stallPcA)   : 32'(stallPcB),   32'(expStall));
      checkOutput({tag, "_stallIfid"}, (inst == 0) ? 32'(stallIfidA) : 32'(stallIfidB), 32'(expStall));
      checkOutput({tag, "_bubble"},    (inst == 0) ? 32'(bubbleA)    : 32'(bubbleB),    32'(expStall));
      e.inst  = inst;
      e.tag   = tag;
      e.sel   = expSel;
      e.valid = expValid;
      e.cnt   = expCnt;
      sbQ.push_back(e);
      @(negedge clk);
   endtask

   // Scoreboard consumer: registered outputs settle just after each rising edge.
   always @(posedge clk) begin
      sb_t e;
      #1;
      if (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         checkOutput({e.tag, "_sel"},   (e.inst == 0) ? 32'(selA)   : 32'(selB),   32'(e.sel));
         checkOutput({e.tag, "_valid"}, (e.inst == 0) ? 32'(validA) : 32'(validB), 32'(e.valid));
         checkOutput({e.tag, "_cnt"},   (e.inst == 0) ? 32'(cntA)   : 32'(cntB),   32'(e.cnt));
      end
   end

   // Reset both instances for one edge and check the reset values.
   task automatic resetPulse(input string tag);
      setIdle();
      reset = 1'b1;
      #1;
      checkOutput({tag, "_selA"},   32'(selA),     32'h0);
      checkOutput({tag, "_validA"}, 32'(validA),   32'h0);
      checkOutput({tag, "_cntA"},   32'(cntA),     32'h0);
      checkOutput({tag, "_stallA"}, 32'(stallPcA), 32'h0);
      checkOutput({tag, "_selB"},   32'(selB),     32'h0);
      checkOutput({tag, "_cntB"},   32'(cntB),     32'h0);
      checkOutput({tag, "_stallB"}, 32'(stallPcB), 32'h0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Hard stop if the sequence ever wedges.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      reset = 1'b1;
      resetPulse("rst0");

      // Forwarding selects (LOAD_LAT=1 instance).
      setIn(1, 0, 5'd3, 5'd0, 2'b01, 5'd3, 1, 0, 5'd0, 0, 5'd0, 0);
      applyStimulus(0, "fwdEx", 0, 4'b0001, 1, 16'd0);
      setIn(1, 0, 5'd0, 5'd5, 2'b10, 5'd5, 1, 0, 5'd5, 1, 5'd0, 0);
      applyStimulus(0, "exOverMem", 0, 4'b0100, 1, 16'd0);
      setIn(1, 0, 5'd0, 5'd5, 2'b10, 5'd5, 0, 0, 5'd5, 1, 5'd0, 0);
      applyStimulus(0, "fwdMem", 0, 4'b1000, 1, 16'd0);
      setIn(1, 0, 5'd0, 5'd0, 2'b10, 5'd0, 1, 0, 5'd0, 1, 5'd0, 0);
      applyStimulus(0, "reg0", 0, 4'b0000, 1, 16'd0);
      setIn(1, 0, 5'd9, 5'd0, 2'b01, 5'd1, 1, 0, 5'd2, 1, 5'd9, 1);
      applyStimulus(0, "wbOnly", 0, 4'b0000, 1, 16'd0);
      setIn(1, 0, 5'd4, 5'd6, 2'b11, 5'd6, 1, 0, 5'd4, 1, 5'd0, 0);
      applyStimulus(0, "bothSrc", 0, 4'b0110, 1, 16'd0);
      setIn(1, 0, 5'd4, 5'd6, 2'b00, 5'd6, 1, 0, 5'd4, 1, 5'd0, 0);
      applyStimulus(0, "unused", 0, 4'b0000, 1, 16'd0);
      setIn(0, 0, 5'd4, 5'd6, 2'b11, 5'd6, 1, 0, 5'd4, 1, 5'd0, 0);
      applyStimulus(0, "invalid", 0, 4'b0000, 0, 16'd0);
      setIn(1, 1, 5'd4, 5'd6, 2'b11, 5'd6, 1, 0, 5'd4, 1, 5'd0, 0);
      applyStimulus(0, "flushFwd", 0, 4'b0000, 0, 16'd0);
      setIn(1, 0, 5'd8, 5'd2, 2'b10, 5'd8, 1, 1, 5'd0, 0, 5'd0, 0);
      applyStimulus(0, "loadNoUse", 0, 4'b0000, 1, 16'd0);
      setIn(1, 0, 5'd0, 5'd0, 2'b11, 5'd0, 1, 1, 5'd0, 0, 5'd0, 0);
      applyStimulus(0, "loadR0", 0, 4'b0000, 1, 16'd0);

      // Load-use with LOAD_LAT=1: one bubble, then forwarded from MEM.
      resetPulse("rst1");
      setIn(1, 0, 5'd7, 5'd0, 2'b01, 5'd7, 1, 1, 5'd0, 0, 5'd0, 0);
      applyStimulus(0, "lu1Stall", 1, 4'b0000, 0, 16'd1);
      setIn(1, 0, 5'd7, 5'd0, 2'b01, 5'd0, 0, 0, 5'd7, 1, 5'd0, 0);
      applyStimulus(0, "lu1Fwd", 0, 4'b0010, 1, 16'd1);
      setIdle();
      applyStimulus(0, "lu1After", 0, 4'b0000, 0, 16'd1);

      // Load-use with LOAD_LAT=3: exactly three stall cycles.
      resetPulse("rst2");
      setIn(1, 0, 5'd7, 5'd0, 2'b01, 5'd7, 1, 1, 5'd0, 0, 5'd0, 0);
      applyStimulus(1, "lu3s1", 1, 4'b0000, 0, 16'd1);
      applyStimulus(1, "lu3s2", 1, 4'b0000, 0, 16'd2);
      applyStimulus(1, "lu3s3", 1, 4'b0000, 0, 16'd3);
      setIn(1, 0, 5'd7, 5'd0, 2'b01, 5'd0, 0, 0, 5'd0, 0, 5'd7, 1);
      applyStimulus(1, "lu3Done", 0, 4'b0000, 1, 16'd3);

      // Flush in the second stall cycle.
      resetPulse("rst3");
      setIn(1, 0, 5'd7, 5'd0, 2'b01, 5'd7, 1, 1, 5'd0, 0, 5'd0, 0);
      applyStimulus(1, "flS1", 1, 4'b0000, 0, 16'd1);
      flush = 1'b1;
      applyStimulus(1, "flS2", 0, 4'b0000, 0, 16'd1);
      setIn(1, 0, 5'd7, 5'd0, 2'b01, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
      applyStimulus(1, "flIdle", 0, 4'b0000, 1, 16'd1);

      // Saturation of the 4-bit counter under a permanently held hazard.
      resetPulse("rst4");
      setIn(1, 0, 5'd7, 5'd0, 2'b01, 5'd7, 1, 1, 5'd0, 0, 5'd0, 0);
      for (int i = 0; i < 18; i++) begin
         applyStimulus(1, $sformatf("sat%0d", i), 1, 4'b0000, 0, (i + 1 > 15) ? 16'd15 : 16'(i + 1));
      end
      applyStimulus(1, "satMore", 1, 4'b0000, 0, 16'd15);

      // dutB is now in STALL; assert reset between edges.
      setIdle();
      #1;
      checkOutput("midStall", 32'(stallPcB), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("asyncRstStall", 32'(stallPcB), 32'h0);
      checkOutput("asyncRstBubble", 32'(bubbleB), 32'h0);
      checkOutput("asyncRstCnt", 32'(cntB), 32'h0);
      checkOutput("asyncRstValid", 32'(validB), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1, "postRst", 0, 4'b0000, 0, 16'd0);
      applyStimulus(1, "postRst2", 0, 4'b0000, 0, 16'd0);

      @(negedge clk);
      if (sbQ.size() != 0) begin
         checkOutput("sbDrain", 32'(sbQ.size()), 32'h0);
      end
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
